// File: rtl/pt8211_adc_capture.sv
// Master-side capture of a 16-bit stereo serial ADC link (32 BCK per frame, WS low = left).
// Completed left/right pairs are held on a registered valid/ready output with overrun tracking.
module pt8211_adc_capture #(
  parameter int unsigned I2S_MODE = 0
) (
  input  logic        clk_1p536m,
  input  logic        rst_n,
  input  logic        en,
  input  logic        iready,
  input  logic        clr_ovr,
  input  logic        ADC_DOUT,
  output logic        ADC_BCK,
  output logic        ADC_WS,
  output logic [15:0] odata_left,
  output logic [15:0] odata_right,
  output logic        ovalid,
  output logic        ovr,
  output logic [7:0]  ovr_cnt
);

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [4:0]  b_cnt_q, b_cnt_d;
  logic        ws_q;
  logic [15:0] shift_q, shift_d;
  logic [15:0] lhold_q, lhold_d;
  logic [15:0] dl_q, dl_d;
  logic [15:0] dr_q, dr_d;
  logic        vld_q, vld_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        primed_q, primed_d;

  logic [4:0]  pos;
  logic [15:0] word_w;
  logic        left_done, right_done, xfer, ovf;

  // In I2S mode the MSB arrives one BCK late, so frame position lags the counter by one.
  assign pos        = (I2S_MODE != 0) ? (b_cnt_q - 5'd1) : b_cnt_q;
  assign word_w     = {shift_q[14:0], ADC_DOUT};
  assign left_done  = en & (pos == 5'd15);
  assign right_done = en & (pos == 5'd31) & primed_q;
  assign xfer       = vld_q & iready;
  assign ovf        = right_done & vld_q & ~iready;

  always_comb begin
    b_cnt_d  = en ? (b_cnt_q + 5'd1) : 5'd0;
    primed_d = en & (primed_q | (b_cnt_q == 5'd31));
    shift_d  = en ? word_w : shift_q;
    lhold_d  = left_done ? word_w : lhold_q;
    dl_d     = dl_q;
    dr_d     = dr_q;
    vld_d    = vld_q;
    ovr_d    = ovr_q;
    cnt_d    = cnt_q;
    if (right_done) begin
      dl_d  = lhold_q;
      dr_d  = word_w;
      vld_d = 1'b1;
    end else if (xfer) begin
      vld_d = 1'b0;
    end
    // A clear on the same edge as an overrun still records that overrun.
    if (clr_ovr) begin
      ovr_d = ovf;
      cnt_d = {7'd0, ovf};
    end else if (ovf) begin
      ovr_d = 1'b1;
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk_1p536m or negedge rst_n) begin
    if (!rst_n) begin
      b_cnt_q  <= '0;
      shift_q  <= '0;
      lhold_q  <= '0;
      dl_q     <= '0;
      dr_q     <= '0;
      vld_q    <= 1'b0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      b_cnt_q  <= b_cnt_d;
      shift_q  <= shift_d;
      lhold_q  <= lhold_d;
      dl_q     <= dl_d;
      dr_q     <= dr_d;
      vld_q    <= vld_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  // WS changes on the falling edge so the ADC sees it stable at the next rising edge.
  always_ff @(negedge clk_1p536m or negedge rst_n) begin
    if (!rst_n) ws_q <= 1'b0;
    else        ws_q <= en & b_cnt_q[4];
  end

  assign ADC_BCK     = clk_1p536m;
  assign ADC_WS      = ws_q;
  assign odata_left  = dl_q;
  assign odata_right = dr_q;
  assign ovalid      = vld_q;
  assign ovr         = ovr_q;
  assign ovr_cnt     = cnt_q;

endmodule

// File: tb/tb_pt8211_adc_capture.sv
// Bench for pt8211_adc_capture: one instance per framing mode, driven by a frame-table ADC model.
module tb_pt8211_adc_capture;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic iready = 1'b1;
  logic clr_ovr = 1'b0;
  logic [1:0] dout = '0;
  logic [1:0] bck, ws, ov, ovr;
  logic [1:0][15:0] ol, orr;
  logic [1:0][7:0] oc;

  always #10 clk = ~clk;

  pt8211_adc_capture #(.I2S_MODE(0)) u_dut0 (
    .clk_1p536m(clk), .rst_n(rst_n), .en(en), .iready(iready), .clr_ovr(clr_ovr),
    .ADC_DOUT(dout[0]), .ADC_BCK(bck[0]), .ADC_WS(ws[0]),
    .odata_left(ol[0]), .odata_right(orr[0]), .ovalid(ov[0]), .ovr(ovr[0]), .ovr_cnt(oc[0])
  );

  pt8211_adc_capture #(.I2S_MODE(1)) u_dut1 (
    .clk_1p536m(clk), .rst_n(rst_n), .en(en), .iready(iready), .clr_ovr(clr_ovr),
    .ADC_DOUT(dout[1]), .ADC_BCK(bck[1]), .ADC_WS(ws[1]),
    .odata_left(ol[1]), .odata_right(orr[1]), .ovalid(ov[1]), .ovr(ovr[1]), .ovr_cnt(oc[1])
  );

  int total = 0;
  int bad = 0;

  // Words the ADC sends per frame (frame 0 = first frame after enable), per instance.
  logic [15:0] wl [2][16];
  logic [15:0] wr [2][16];

  // Model state: n = enabled rising edges since enable; expected outputs per instance.
  int n = 0;
  logic [1:0] m_v = '0, m_o = '0;
  logic [1:0][15:0] m_l = '0, m_r = '0;
  logic [1:0][7:0] m_c = '0;

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s mode%0d at %0t: actual=%0h required=%0h", nm, m, $time, act, exp);
    end
  endtask

  function automatic int fidx(input int t);
    int f;
    f = t / 32;
    return (f > 15) ? 15 : f;
  endfunction

  // A pair becomes visible when the last bit of a frame is taken, unless still in the first 32 edges.
  function automatic logic is_done(input int nn, input int m, input logic e);
    return e && (nn >= 32) && (((nn - m) % 32) == 31);
  endfunction

  function automatic logic is_ovf(input int nn, input int m, input logic e, input logic v, input logic rdy);
    return is_done(nn, m, e) && v && !rdy;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n   <= 0;
      m_v <= '0;
      m_o <= '0;
      m_l <= '0;
      m_r <= '0;
      m_c <= '0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (is_done(n, m, en)) begin
          m_l[m] <= wl[m][fidx(n - m)];
          m_r[m] <= wr[m][fidx(n - m)];
          m_v[m] <= 1'b1;
        end else if (m_v[m] && iready) begin
          m_v[m] <= 1'b0;
        end
        if (clr_ovr) begin
          m_o[m] <= is_ovf(n, m, en, m_v[m], iready);
          m_c[m] <= is_ovf(n, m, en, m_v[m], iready) ? 8'd1 : 8'd0;
        end else if (is_ovf(n, m, en, m_v[m], iready)) begin
          m_o[m] <= 1'b1;
          m_c[m] <= (m_c[m] == 8'hFF) ? 8'hFF : m_c[m] + 8'd1;
        end
      end
      n <= en ? n + 1 : 0;
    end
  end

  // ADC model: bit for the upcoming rising edge, launched after the falling edge.
  function automatic logic tx_bit(input int m);
    int t, p;
    logic [15:0] w;
    t = n - m;
    if (!en || t < 0) return 1'b0;
    p = t % 32;
    w = (p >= 16) ? wr[m][fidx(t)] : wl[m][fidx(t)];
    return w[15 - (p % 16)];
  endfunction

  always @(negedge clk) begin
    #1;
    for (int m = 0; m < 2; m++) dout[m] = tx_bit(m);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        chk("ovalid", m, {31'd0, ov[m]}, {31'd0, m_v[m]});
        chk("odata_left", m, {16'd0, ol[m]}, {16'd0, m_l[m]});
        chk("odata_right", m, {16'd0, orr[m]}, {16'd0, m_r[m]});
        chk("ovr", m, {31'd0, ovr[m]}, {31'd0, m_o[m]});
        chk("ovr_cnt", m, {24'd0, oc[m]}, {24'd0, m_c[m]});
      end
      @(negedge clk);
      #1;
      for (int m = 0; m < 2; m++)
        chk("ws", m, {31'd0, ws[m]}, {31'd0, (en && ((n % 32) >= 16))});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_to(input int k);
    int guard;
    guard = 0;
    while (n < k && guard < 2000) begin
      tick();
      guard++;
    end
    if (n < k) begin
      total++;
      bad++;
      $display("FAIL run_to: reached=%0d required=%0d", n, k);
    end
  endtask

  task automatic set_tables0(input logic [15:0] lbase, input logic [15:0] rbase, input logic inc);
    for (int f = 0; f < 16; f++) begin
      wl[0][f] = inc ? lbase + 16'(f) : lbase;
      wr[0][f] = inc ? rbase + 16'(f) : rbase;
    end
  endtask

  initial begin
    set_tables0(16'hA55A, 16'h1234, 1'b0);
    for (int f = 0; f < 16; f++) begin
      wl[1][f] = 16'h8001;
      wr[1][f] = 16'h7FFE;
    end

    // Reset, then idle with capture disabled.
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    chk("idle_ovalid", 0, {31'd0, ov[0]}, 32'd0);
    chk("idle_ws", 0, {31'd0, ws[0]}, 32'd0);
    chk("idle_left", 0, {16'd0, ol[0]}, 32'd0);

    // Continuous capture, both framing modes.
    en = 1'b1;
    run_to(32);
    chk("i2s_before_first", 1, {31'd0, ov[1]}, 32'd0);
    tick();
    chk("i2s_first_valid", 1, {31'd0, ov[1]}, 32'd1);
    chk("i2s_first_left", 1, {16'd0, ol[1]}, 32'h8001);
    chk("i2s_first_right", 1, {16'd0, orr[1]}, 32'h7FFE);
    run_to(63);
    chk("lj_before_first", 0, {31'd0, ov[0]}, 32'd0);
    tick();
    chk("lj_first_valid", 0, {31'd0, ov[0]}, 32'd1);
    chk("lj_first_left", 0, {16'd0, ol[0]}, 32'hA55A);
    chk("lj_first_right", 0, {16'd0, orr[0]}, 32'h1234);
    tick();
    chk("lj_valid_one_cycle", 0, {31'd0, ov[0]}, 32'd0);
    run_to(96);
    chk("lj_second_valid", 0, {31'd0, ov[0]}, 32'd1);
    run_to(112);
    chk("ws_before_negedge", 0, {31'd0, ws[0]}, 32'd0);
    @(negedge clk);
    #2;
    chk("ws_after_negedge", 0, {31'd0, ws[0]}, 32'd1);

    // Backpressure across three completions, then overrun clearing.
    en = 1'b0;
    repeat (2) tick();
    set_tables0(16'h0100, 16'h0000, 1'b1);
    iready = 1'b0;
    en = 1'b1;
    run_to(128);
    chk("hold_valid", 0, {31'd0, ov[0]}, 32'd1);
    chk("hold_right", 0, {16'd0, orr[0]}, 32'd3);
    chk("hold_left", 0, {16'd0, ol[0]}, 32'h0103);
    chk("hold_ovr", 0, {31'd0, ovr[0]}, 32'd1);
    chk("hold_cnt", 0, {24'd0, oc[0]}, 32'd2);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("clr_ovr", 0, {31'd0, ovr[0]}, 32'd0);
    chk("clr_cnt", 0, {24'd0, oc[0]}, 32'd0);
    run_to(159);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("clr_with_ovf_ovr", 0, {31'd0, ovr[0]}, 32'd1);
    chk("clr_with_ovf_cnt", 0, {24'd0, oc[0]}, 32'd1);
    chk("clr_with_ovf_right", 0, {16'd0, orr[0]}, 32'd4);

    // Disable mid-frame; held pair survives and drains; re-enable needs two frames.
    run_to(170);
    en = 1'b0;
    @(negedge clk);
    #2;
    chk("dis_ws", 0, {31'd0, ws[0]}, 32'd0);
    repeat (3) tick();
    chk("dis_hold_valid", 0, {31'd0, ov[0]}, 32'd1);
    chk("dis_hold_right", 0, {16'd0, orr[0]}, 32'd4);
    chk("dis_hold_left", 0, {16'd0, ol[0]}, 32'h0104);
    iready = 1'b1;
    tick();
    chk("dis_drain", 0, {31'd0, ov[0]}, 32'd0);
    set_tables0(16'h3000, 16'h2000, 1'b1);
    en = 1'b1;
    run_to(63);
    chk("reen_before", 0, {31'd0, ov[0]}, 32'd0);
    tick();
    chk("reen_valid", 0, {31'd0, ov[0]}, 32'd1);
    chk("reen_left", 0, {16'd0, ol[0]}, 32'h3001);
    chk("reen_right", 0, {16'd0, orr[0]}, 32'h2001);
    iready = 1'b0;

    // Asynchronous reset between clock edges while a pair is held.
    run_to(84);
    @(negedge clk);
    #3;
    chk("pre_rst_ws", 0, {31'd0, ws[0]}, 32'd1);
    chk("pre_rst_valid", 0, {31'd0, ov[0]}, 32'd1);
    chk("pre_rst_cnt", 0, {24'd0, oc[0]}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rst_valid", 0, {31'd0, ov[0]}, 32'd0);
    chk("rst_left", 0, {16'd0, ol[0]}, 32'd0);
    chk("rst_right", 0, {16'd0, orr[0]}, 32'd0);
    chk("rst_cnt", 0, {24'd0, oc[0]}, 32'd0);
    chk("rst_ovr", 0, {31'd0, ovr[0]}, 32'd0);
    chk("rst_ws", 0, {31'd0, ws[0]}, 32'd0);
    chk("rst_valid", 1, {31'd0, ov[1]}, 32'd0);
    #2;
    rst_n = 1'b1;
    iready = 1'b1;
    repeat (70) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
